// File: rtl/memory_bridge_if.sv
// Signal bundle between the CPU data port, RAM, framebuffer and keyboard and the memory bridge.
// "slave" is the bridge side; "master" is the surrounding system (CPU, memories, keyboard).
interface memory_bridge_if;
  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic [13:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata;
  logic        fb_valid;
  logic        fb_ready;
  logic [12:0] fb_addr;
  logic [15:0] fb_wdata;
  logic [15:0] fb_rdata;
  logic        kbd_strobe;
  logic [15:0] kbd_code;
  logic        screen_overflow;
  logic        bad_access;

  modport slave (
    input  addressM, outM, writeM, ram_rdata, fb_ready, fb_rdata, kbd_strobe, kbd_code,
    output inM, ram_addr, ram_wdata, ram_we, fb_valid, fb_addr, fb_wdata,
           screen_overflow, bad_access
  );

  modport master (
    output addressM, outM, writeM, ram_rdata, fb_ready, fb_rdata, kbd_strobe, kbd_code,
    input  inM, ram_addr, ram_wdata, ram_we, fb_valid, fb_addr, fb_wdata,
           screen_overflow, bad_access
  );
endinterface

// File: rtl/memory_bridge.sv
// Hack data-memory stage: decodes RAM/screen/keyboard, answers reads combinationally and
// buffers screen writes in a FIFO drained to the framebuffer over valid/ready.
module memory_bridge #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          FWD_EN     = 1'b1
) (
  input logic            clk,
  input logic            reset_n,
  memory_bridge_if.slave bus
);
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(FIFO_DEPTH);

  logic is_ram, is_scr, is_kbd, is_bad;
  assign is_ram = ~bus.addressM[14];
  assign is_scr = (bus.addressM[14:13] == 2'b10);
  assign is_kbd = (bus.addressM == 15'h6000);
  assign is_bad = (bus.addressM[14:13] == 2'b11) & ~is_kbd;

  logic [12:0]     addr_q [FIFO_DEPTH];
  logic [15:0]     data_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, bad_q;
  logic [15:0]     kbd_q;

  logic fb_valid, push_req, push, pop;
  assign fb_valid = (count_q != '0);
  assign pop      = fb_valid & bus.fb_ready;
  assign push_req = bus.writeM & is_scr;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push     = push_req & ((count_q != Full) | pop);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      bad_q    <= 1'b0;
      kbd_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (push_req & ~push) ovf_q <= 1'b1;
      bad_q <= is_bad;
      if (bus.kbd_strobe) kbd_q <= bus.kbd_code;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= bus.addressM[12:0];
      data_q[wr_ptr_q] <= bus.outM;
    end
  end

  // Scan oldest to newest so the newest matching entry wins.
  logic            fwd_hit;
  logic [15:0]     fwd_data;
  logic [PtrW-1:0] idx;
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      idx = rd_ptr_q + PtrW'(i);
      if ((CntW'(i) < count_q) && (addr_q[idx] == bus.addressM[12:0])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  always_comb begin
    bus.inM = '0;
    if (is_ram) begin
      bus.inM = bus.ram_rdata;
    end else if (is_scr) begin
      bus.inM = (FWD_EN && fwd_hit) ? fwd_data : bus.fb_rdata;
    end else if (is_kbd) begin
      bus.inM = kbd_q;
    end
  end

  assign bus.ram_addr        = bus.addressM[13:0];
  assign bus.ram_wdata       = bus.outM;
  assign bus.ram_we          = bus.writeM & is_ram;
  assign bus.fb_valid        = fb_valid;
  assign bus.fb_addr         = addr_q[rd_ptr_q];
  assign bus.fb_wdata        = data_q[rd_ptr_q];
  assign bus.screen_overflow = ovf_q;
  assign bus.bad_access      = bad_q;
endmodule

// File: tb/tb_memory_bridge.sv
// Bench for memory_bridge: directed CPU traffic, framebuffer pops checked by a scoreboard
// queue against the order of accepted screen writes.
module tb_memory_bridge;
  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  memory_bridge_if bus ();

  memory_bridge #(
    .FIFO_DEPTH(4),
    .FWD_EN    (1'b1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [28:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic [14:0] a, input logic [15:0] d, input logic we);
    bus.addressM = a;
    bus.outM     = d;
    bus.writeM   = we;
  endtask

  task automatic scr_wr(input logic [14:0] a, input logic [15:0] d, input bit accept);
    cpu(a, d, 1'b1);
    if (accept) exp_q.push_back({a[12:0], d});
  endtask

  // Monitor: every handshake seen mid-cycle must match the oldest expected write.
  initial begin
    logic [28:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && bus.fb_valid && bus.fb_ready) begin
        if (exp_q.size() == 0) begin
          chk("fb_unexpected_pop", {3'b0, bus.fb_addr, bus.fb_wdata}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("fb_addr", {19'b0, bus.fb_addr}, {19'b0, e[28:16]});
          chk("fb_wdata", {16'b0, bus.fb_wdata}, {16'b0, e[15:0]});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    errors = 0;
    checks = 0;
    reset_n        = 1'b0;
    cpu(15'h6000, 16'h0, 1'b0);
    bus.ram_rdata  = '0;
    bus.fb_ready   = 1'b0;
    bus.fb_rdata   = '0;
    bus.kbd_strobe = 1'b0;
    bus.kbd_code   = '0;
    #12;
    chk("rst_fb_valid", bus.fb_valid, 0);
    chk("rst_overflow", bus.screen_overflow, 0);
    chk("rst_bad", bus.bad_access, 0);
    chk("rst_kbd", bus.inM, 16'h0);
    reset_n = 1'b1;
    step();

    // RAM pass-through
    cpu(15'h0010, 16'h1234, 1'b1);
    bus.ram_rdata = 16'hBEEF;
    #1;
    chk("ram_we", bus.ram_we, 1);
    chk("ram_addr", bus.ram_addr, 14'h0010);
    chk("ram_wdata", bus.ram_wdata, 16'h1234);
    chk("ram_inM", bus.inM, 16'hBEEF);
    step();
    cpu(15'h0010, 16'h0, 1'b0);
    #1;
    chk("ram_we_rd", bus.ram_we, 0);
    chk("ram_fb_idle", bus.fb_valid, 0);

    // Screen drain in order
    bus.fb_ready = 1'b0;
    scr_wr(15'h4000, 16'hAAAA, 1'b1);
    step();
    scr_wr(15'h4001, 16'h5555, 1'b1);
    chk("scr_valid", bus.fb_valid, 1);
    chk("scr_head_addr", bus.fb_addr, 13'h0000);
    chk("scr_head_data", bus.fb_wdata, 16'hAAAA);
    step();
    cpu(15'h0000, 16'h0, 1'b0);
    step();
    step();
    chk("scr_hold_data", bus.fb_wdata, 16'hAAAA);
    bus.fb_ready = 1'b1;
    step();
    step();
    step();
    chk("scr_drained", bus.fb_valid, 0);

    // Overflow: fifth write dropped
    bus.fb_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      scr_wr(15'h4000 + 15'(i), 16'h0100 + 16'(i), i < 4);
      step();
    end
    cpu(15'h0000, 16'h0, 1'b0);
    chk("ovf_set", bus.screen_overflow, 1);
    bus.fb_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("ovf_drained", bus.fb_valid, 0);
    chk("ovf_sticky", bus.screen_overflow, 1);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    chk("ovf_cleared", bus.screen_overflow, 0);

    // Overflow avoided: pop on the same edge as the fifth write
    bus.fb_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) bus.fb_ready = 1'b1;
      scr_wr(15'h4010 + 15'(i), 16'h0200 + 16'(i), 1'b1);
      step();
    end
    cpu(15'h0000, 16'h0, 1'b0);
    for (int i = 0; i < 6; i++) step();
    chk("full_pop_no_ovf", bus.screen_overflow, 0);
    chk("full_pop_drained", bus.fb_valid, 0);

    // Forwarding
    bus.fb_ready = 1'b0;
    bus.fb_rdata = 16'hDEAD;
    scr_wr(15'h4005, 16'h1111, 1'b1);
    step();
    scr_wr(15'h4005, 16'h2222, 1'b1);
    step();
    cpu(15'h4005, 16'h0, 1'b0);
    #1;
    chk("fwd_newest", bus.inM, 16'h2222);
    cpu(15'h4006, 16'h0, 1'b0);
    #1;
    chk("fwd_miss", bus.inM, 16'hDEAD);
    bus.fb_ready = 1'b1;
    cpu(15'h0000, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    cpu(15'h4005, 16'h0, 1'b0);
    #1;
    chk("fwd_empty", bus.inM, 16'hDEAD);

    // Keyboard and unmapped
    bus.kbd_code   = 16'h0041;
    bus.kbd_strobe = 1'b1;
    step();
    bus.kbd_strobe = 1'b0;
    bus.kbd_code   = 16'h7777;
    cpu(15'h6000, 16'h0, 1'b0);
    #1;
    chk("kbd_code", bus.inM, 16'h0041);
    bus.kbd_code   = 16'h0000;
    bus.kbd_strobe = 1'b1;
    step();
    bus.kbd_strobe = 1'b0;
    bus.kbd_code   = 16'h0041;
    chk("kbd_zero", bus.inM, 16'h0000);
    cpu(15'h6000, 16'hFFFF, 1'b1);
    #1;
    chk("kbd_wr_ram_we", bus.ram_we, 0);
    step();
    cpu(15'h6000, 16'h0, 1'b0);
    chk("kbd_wr_ignored", bus.inM, 16'h0000);
    chk("kbd_wr_not_bad", bus.bad_access, 0);
    chk("kbd_wr_no_fb", bus.fb_valid, 0);
    cpu(15'h6001, 16'h0, 1'b0);
    #1;
    chk("unmapped_inM", bus.inM, 16'h0000);
    step();
    chk("bad_rd_pulse", bus.bad_access, 1);
    cpu(15'h0000, 16'h0, 1'b0);
    step();
    chk("bad_clear", bus.bad_access, 0);
    cpu(15'h7FFF, 16'hFFFF, 1'b1);
    #1;
    chk("bad_wr_ram_we", bus.ram_we, 0);
    step();
    cpu(15'h0000, 16'h0, 1'b0);
    chk("bad_wr_pulse", bus.bad_access, 1);
    chk("bad_wr_no_fb", bus.fb_valid, 0);

    // Reset mid-drain discards pending entries
    bus.fb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      scr_wr(15'h4100 + 15'(i), 16'h0300 + 16'(i), 1'b0);
      step();
    end
    cpu(15'h0000, 16'h0, 1'b0);
    chk("rst_mid_pending", bus.fb_valid, 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", bus.fb_valid, 0);
    chk("rst_mid_ovf", bus.screen_overflow, 0);
    reset_n = 1'b1;
    step();
    bus.fb_ready = 1'b1;
    scr_wr(15'h5FFF, 16'hCAFE, 1'b1);
    step();
    cpu(15'h0000, 16'h0, 1'b0);
    step();
    step();
    chk("post_rst_drained", bus.fb_valid, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
